// File: rtl/vec_mac_stream.sv
// 8-lane streaming int8 dot-product engine that drains its accumulators serially
// into the quantizer. Define VEC_MAC_SAT_EN for saturating accumulation and the sat_o port.
module vec_mac_lane #(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [7:0]       x_i,
    input  logic [7:0]       w_i,
`ifdef VEC_MAC_SAT_EN
    output logic             ovf_o,
`endif
    output logic [ACC_W-1:0] sum_o
);
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]        raw;

    assign prod     = $signed(x_i) * $signed(w_i);
    assign prod_ext = ACC_W'(prod);
    assign raw      = acc_i + prod_ext;

`ifdef VEC_MAC_SAT_EN
    // Same-sign operands with a sign flip in the sum means overflow; clamp toward the operand sign.
    assign ovf_o = (acc_i[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc_i[ACC_W-1]);
    assign sum_o = !ovf_o ? raw :
                   acc_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign sum_o = raw;
`endif
endmodule

module vec_mac_stream #(
    parameter int LANES = 8,
    parameter int K_LEN = 8,
    parameter int ACC_W = 32
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [7:0]         x_i,
    input  logic [8*LANES-1:0] w_i,
    output logic [ACC_W-1:0]   dout_o,
    output logic               dout_valid_o,
    output logic               q_en_o,
    output logic               busy_o,
    output logic               done_o
`ifdef VEC_MAC_SAT_EN
    ,
    output logic               sat_o
`endif
);
    localparam int DW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [7:0]    LAST_BEAT = 8'(K_LEN - 1);
    localparam logic [DW-1:0] LAST_D    = DW'(LANES - 1);
    localparam logic [DW-1:0] PENULT_D  = DW'(LANES - 2);

    logic [1:0]                  state_q, state_d;
    logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d, sum;
    logic [7:0]                  cnt_q, cnt_d;
    logic [DW-1:0]               didx_q, didx_d;
    logic [ACC_W-1:0]            dout_q, dout_d;
    logic                        vld_q, vld_d, qen_q, qen_d, done_q, done_d;
`ifdef VEC_MAC_SAT_EN
    logic [LANES-1:0]            ovf;
    logic                        sat_q, sat_d;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vec_mac_lane #(.ACC_W(ACC_W)) u_lane (
            .acc_i (acc_q[l]),
            .x_i   (x_i),
            .w_i   (w_i[8*l +: 8]),
`ifdef VEC_MAC_SAT_EN
            .ovf_o (ovf[l]),
`endif
            .sum_o (sum[l])
        );
    end

    // Output registers are loaded one cycle ahead so word d appears while didx_q == d.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        didx_d  = didx_q;
        dout_d  = '0;
        vld_d   = 1'b0;
        qen_d   = 1'b0;
        done_d  = 1'b0;
`ifdef VEC_MAC_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef VEC_MAC_SAT_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            S_ACC: begin
                if (in_valid_i) begin
                    acc_d = sum;
                    cnt_d = cnt_q + 8'd1;
`ifdef VEC_MAC_SAT_EN
                    sat_d = sat_q | (|ovf);
`endif
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DRAIN;
                        didx_d  = '0;
                        dout_d  = sum[0];
                        vld_d   = 1'b1;
                        qen_d   = 1'b1;
                        done_d  = (LANES == 1);
                    end
                end
            end
            S_DRAIN: begin
                if (didx_q == LAST_D) begin
                    state_d = S_IDLE;
                    didx_d  = '0;
                end else begin
                    didx_d  = didx_q + DW'(1);
                    dout_d  = acc_q[didx_q + DW'(1)];
                    vld_d   = 1'b1;
                    done_d  = (didx_q == PENULT_D);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            didx_q  <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            qen_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef VEC_MAC_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            didx_q  <= didx_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            qen_q   <= qen_d;
            done_q  <= done_d;
`ifdef VEC_MAC_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign in_ready_o   = (state_q == S_ACC);
    assign busy_o       = (state_q != S_IDLE);
    assign dout_o       = dout_q;
    assign dout_valid_o = vld_q;
    assign q_en_o       = qen_q;
    assign done_o       = done_q;
`ifdef VEC_MAC_SAT_EN
    assign sat_o        = sat_q;
`endif
endmodule

// File: tb/tb_vec_mac_stream.sv
// Directed bench for vec_mac_stream: default 8x8x32 instance plus a 16-bit, K_LEN=2 instance.
module tb_vec_mac_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start16 = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  x = '0;
    logic [63:0] w = '0;
    logic        in_ready, dout_valid, q_en, busy, done;
    logic [31:0] dout;
    logic        in_ready16, dout_valid16, q_en16, busy16, done16;
    logic [15:0] dout16;
`ifdef VEC_MAC_SAT_EN
    logic        sat, sat16;
`endif
    int checks = 0;
    int failures = 0;
    int e1[8], e2[8];

    always #5 clk = ~clk;

    vec_mac_stream u_dut (
        .clk_i(clk), .rstn_i(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .x_i(x), .w_i(w), .dout_o(dout),
        .dout_valid_o(dout_valid), .q_en_o(q_en), .busy_o(busy), .done_o(done)
`ifdef VEC_MAC_SAT_EN
        , .sat_o(sat)
`endif
    );

    vec_mac_stream #(.LANES(8), .K_LEN(2), .ACC_W(16)) u_d16 (
        .clk_i(clk), .rstn_i(rst_n), .start_i(start16), .in_valid_i(in_valid),
        .in_ready_o(in_ready16), .x_i(x), .w_i(w), .dout_o(dout16),
        .dout_valid_o(dout_valid16), .q_en_o(q_en16), .busy_o(busy16), .done_o(done16)
`ifdef VEC_MAC_SAT_EN
        , .sat_o(sat16)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wvec(input int mode);
        logic [63:0] v;
        v = '0;
        for (int l = 0; l < 8; l++)
            v[8*l +: 8] = (mode == 0) ? 8'sd1 : 8'(l - 4);
        return v;
    endfunction

    // One full vector: start, 8 beats of x=1..8, then check all 8 drain cycles.
    task automatic run_vec(input int wmode, input bit bubbles, input bit hold, input int exp[8]);
        int beats, cyc, first_exp;
        bit v;
        start = 1'b1;
        in_valid = 1'b0;
        step();
        if (!hold) start = 1'b0;
        chk("acc_in_ready", {31'b0, in_ready}, 32'd1);
        chk("acc_busy", {31'b0, busy}, 32'd1);
        beats = 0;
        cyc = 1;
        first_exp = 0;
        while (beats < 8 && cyc < 100) begin
            v = bubbles ? cyc[0] : 1'b1;
            in_valid = v;
            x = 8'(beats + 1);
            w = wvec(wmode);
            if (v && beats == 7) first_exp = cyc + 1;
            step();
            if (v) beats++;
            cyc++;
            if (beats < 8) begin
                checks++;
                assert (in_ready === 1'b1 && dout_valid === 1'b0) else begin
                    failures++;
                    $error("FAIL acc_phase observed=%b%b expected=10", in_ready, dout_valid);
                end
            end
        end
        in_valid = 1'b0;
        chk("beats_bound", beats, 32'd8);
        chk("first_valid_cycle", cyc, first_exp);
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("drain_valid%0d", d), {31'b0, dout_valid}, 32'd1);
            chk($sformatf("drain_word%0d", d), dout, 32'(exp[d]));
            chk($sformatf("drain_qen%0d", d), {31'b0, q_en}, {31'b0, d == 0});
            chk($sformatf("drain_done%0d", d), {31'b0, done}, {31'b0, d == 7});
            chk($sformatf("drain_ready%0d", d), {31'b0, in_ready}, 32'd0);
            step();
        end
        chk("post_valid", {31'b0, dout_valid}, 32'd0);
        chk("post_busy", {31'b0, busy}, 32'd0);
        chk("post_dout", dout, 32'd0);
    endtask

    initial begin
        for (int l = 0; l < 8; l++) begin
            e1[l] = 36;
            e2[l] = 36 * (l - 4);
        end
        #12;
        chk("rst_outs", {26'b0, in_ready, dout_valid, q_en, busy, done, 1'b0}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", {31'b0, busy}, 32'd0);
        in_valid = 1'b1;
        step();
        chk("idle_ignores_valid", {30'b0, busy, in_ready}, 32'd0);
        in_valid = 1'b0;

        run_vec(0, 1'b0, 1'b0, e1);
        run_vec(1, 1'b0, 1'b0, e2);
        run_vec(0, 1'b1, 1'b0, e1);

        // Narrow instance: two (-128)*(-128) beats overflow 16 bits.
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        chk("d16_ready", {31'b0, in_ready16}, 32'd1);
        x = 8'h80;
        w = {8{8'h80}};
        in_valid = 1'b1;
        step();
        chk("d16_no_valid_yet", {31'b0, dout_valid16}, 32'd0);
        step();
        in_valid = 1'b0;
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("d16_valid%0d", d), {31'b0, dout_valid16}, 32'd1);
`ifdef VEC_MAC_SAT_EN
            chk($sformatf("d16_sat_word%0d", d), {16'b0, dout16}, 32'h7fff);
            chk($sformatf("d16_sat_flag%0d", d), {31'b0, sat16}, 32'd1);
`else
            chk($sformatf("d16_wrap_word%0d", d), {16'b0, dout16}, 32'h8000);
`endif
            chk($sformatf("d16_qen%0d", d), {31'b0, q_en16}, {31'b0, d == 0});
            step();
        end
        chk("d16_idle", {30'b0, busy16, dout_valid16}, 32'd0);

        // Reset during the 4th beat aborts the vector.
        start = 1'b1;
        step();
        start = 1'b0;
        w = wvec(0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            x = 8'(k + 1);
            step();
        end
        x = 8'd4;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {27'b0, in_ready, dout_valid, q_en, busy, done}, 32'd0);
        chk("midrst_dout", dout, 32'd0);
        step();
        chk("midrst_hold", {27'b0, in_ready, dout_valid, q_en, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            assert (dout_valid === 1'b0 && busy === 1'b0) else begin
                failures++;
                $error("FAIL no_stray observed=%b%b expected=00", dout_valid, busy);
            end
        end
        in_valid = 1'b0;
        run_vec(0, 1'b0, 1'b0, e1);

        // start held high across two back-to-back vectors.
        run_vec(0, 1'b0, 1'b1, e1);
        run_vec(1, 1'b0, 1'b1, e2);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vec_mac_stream.md
Name: vec_mac_stream

Overview:
- Upstream producer for the 8-lane quantizer.
- Computes 8 signed int8 dot products, y[l] = sum over k of x[k]*W[l][k], with x streamed one element per beat and all 8 weights for that element presented in parallel.
- After K_LEN accepted beats, drains the 8 ACC_W-bit accumulators serially on dout_o for 8 consecutive cycles.
- Emits a one-cycle q_en_o pulse on the first drained word, so its outputs connect directly to the quantizer's din_i and i_q_en.

Parameters:
- LANES, 8, number of output lanes and accumulators, and the drain length. Fixed at 8 for quantizer compatibility.
- K_LEN, 8, accepted input beats per dot product, in the range 1..255.
- ACC_W, 32, accumulator and output width. Must be at least 16. Products are sign-extended to ACC_W.

Ports:
- clk_i  input  1  clock, all logic on the rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  begins a new vector; honoured only in IDLE.
- in_valid_i  input  1  x_i and w_i carry a valid beat.
- in_ready_o  output  1  block accepts beats; high only in ACC.
- x_i  input  8  signed activation element x[k].
- w_i  input  8*LANES  packed signed weights; bits [8l+7:8l] hold W[l][k].
- dout_o  output  ACC_W  signed accumulator word; feeds quantizer din_i.
- dout_valid_o  output  1  dout_o is valid.
- q_en_o  output  1  one-cycle pulse with the first drained word; feeds quantizer i_q_en.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle pulse on the last drained word.

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset rstn_i is asynchronous and active-low.
  - On reset: state=IDLE, all accumulators 0, beat counter 0, drain index 0.
  - On reset, every output is 0: dout_o, dout_valid_o, q_en_o, in_ready_o, busy_o, done_o.
  - Reset asserted mid-ACC or mid-DRAIN aborts immediately. No partial output is emitted afterwards.
- FSM states: IDLE, ACC, DRAIN.
- IDLE:
  - start_i=1 -> ACC on the next edge.
  - On that same edge, clear all LANES accumulators and the beat counter.
  - in_valid_i is ignored in IDLE.
- ACC:
  - in_ready_o=1. A beat is accepted when in_valid_i && in_ready_o.
  - Per accepted beat, for every lane l: acc[l] <= acc[l] + sext(x_i * w_i[l]).
  - The product is a full signed 8x8 -> 16-bit product.
  - Without saturation, the accumulator wraps as two's complement modulo 2^ACC_W.
  - Bubbles (in_valid_i=0) hold all state.
  - The beat counter increments per accepted beat.
  - The beat that brings the count to K_LEN moves the FSM to DRAIN on the same edge. in_ready_o is 0 from the next cycle on.
  - start_i in ACC or DRAIN is ignored. No restart.
- DRAIN:
  - Lasts exactly LANES cycles, with drain index d=0..LANES-1.
  - dout_o=acc[d] and dout_valid_o=1 on every drain cycle.
  - q_en_o=1 only when d=0. done_o=1 only when d=LANES-1.
  - After d=LANES-1, the FSM returns to IDLE. Accumulators are not cleared until the next start.
  - Outputs are registered. With start_i at cycle 0 and K_LEN beats with no bubbles in cycles 1..K_LEN, the first dout_valid_o is at cycle K_LEN+1.
  - No backpressure on the drain side: the downstream quantizer must accept 8 consecutive words.
- Outside DRAIN: dout_o=0, dout_valid_o=0, q_en_o=0.
- Back-to-back operation: start_i is accepted in the cycle after done_o (IDLE). Minimum period is K_LEN+LANES+1 cycles.
- Boundary values:
  - (-128)*(-128)=+16384 must be exact.
  - K_LEN=1 goes IDLE -> ACC (1 beat) -> DRAIN.

Optional Feature:
- Macro VEC_MAC_SAT_EN.
- When defined:
  - Each accumulate saturates to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1] instead of wrapping.
  - Overflow is detected as: the two operands have the same sign and the sum's sign differs.
  - A sticky flag per vector is ORed into an extra output port sat_o (1 bit). sat_o is 0 at reset, cleared on start, and valid throughout DRAIN.
- When undefined: wrap-around arithmetic applies and the sat_o port is absent.

Test Plan:
- Reset, then start; x=1..8 with all weights 1 in every lane, no bubbles -> dout_o = 36 on all 8 drain cycles. q_en_o high only on the first cycle, done_o high only on the 8th. First valid word at cycle 9 after start.
- x=1..8, lane l weights all equal to (l-4) -> dout sequence -144, -108, -72, -36, 0, 36, 72, 108.
- Same as the first test, with in_valid_i low on alternate cycles -> identical results. in_ready_o stays high throughout ACC. Drain starts one cycle after the 8th accepted beat.
- ACC_W=16, K_LEN=2, x=-128, w=-128 in all lanes -> without the macro, dout_o = -32768 in every lane. With VEC_MAC_SAT_EN, dout_o = 32767 and sat_o=1.
- Assert rstn_i low during beat 4 of ACC, release, then rerun the first test -> all outputs 0 during reset, no stray dout_valid_o, and the second run yields 36 on every lane.
- start_i held high through a whole operation, back-to-back -> only the IDLE start is honoured. The second vector begins the cycle after done_o. The drain produces 8 words with a single q_en_o.
